// File: rtl/ram_arb_pkg.sv
// Shared definitions for the dual-port RAM arbiter: requester ids, read-tracking
// entry and default RAM geometry.
package ram_arb_pkg;
  localparam int MEM_WIDTH_DEF = 16;
  localparam int ADDR_SIZE_DEF = 10;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_track_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: grants every requester unless they conflict,
// in which case only the priority side wins.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       conflict,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (conflict) gnt = (prio == REQ_B) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates requesters A and B onto one write port and one registered read port
// of a dual-port RAM, and routes read data back to the issuing side.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_wr,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [MEM_WIDTH-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [MEM_WIDTH-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_wr,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [MEM_WIDTH-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [MEM_WIDTH-1:0] b_rdata,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_blk_select,
  output logic [ADDR_SIZE-1:0] ram_addr_wr,
  output logic [ADDR_SIZE-1:0] ram_addr_rd,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout
);

  logic       prio;
  logic       conflict;
  logic [1:0] pick;
  logic       wr_a, wr_b, rd_a, rd_b;
  rd_track_t  trk0, trk1;

  // Same-type pairs always clash; a write/read pair clashes only on a shared address.
  assign conflict = a_req & b_req & ((a_wr == b_wr) | (a_addr == b_addr));

  rr_pick2 u_pick (
    .req      ({b_req, a_req}),
    .conflict (conflict),
    .prio     (prio),
    .gnt      (pick)
  );

  // Grants are suppressed while reset is held so nothing is accepted.
  assign a_gnt = pick[0] & rst_n;
  assign b_gnt = pick[1] & rst_n;

  assign wr_a = a_gnt & a_wr;
  assign wr_b = b_gnt & b_wr;
  assign rd_a = a_gnt & ~a_wr;
  assign rd_b = b_gnt & ~b_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio        <= REQ_A;
      ram_wr_en   <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_addr_wr <= '0;
      ram_addr_rd <= '0;
      ram_din     <= '0;
      trk0        <= '0;
      trk1        <= '0;
    end else begin
      if (a_gnt && !b_gnt && b_req)      prio <= REQ_B;
      else if (b_gnt && !a_gnt && a_req) prio <= REQ_A;

      ram_wr_en <= wr_a | wr_b;
      if (wr_a) begin
        ram_addr_wr <= a_addr;
        ram_din     <= a_wdata;
      end else if (wr_b) begin
        ram_addr_wr <= b_addr;
        ram_din     <= b_wdata;
      end

      ram_rd_en <= rd_a | rd_b;
      if (rd_a)      ram_addr_rd <= a_addr;
      else if (rd_b) ram_addr_rd <= b_addr;

      // Stage 0 aligns with the RAM command, stage 1 with the RAM data.
      trk0.valid <= rd_a | rd_b;
      trk0.id    <= rd_b ? REQ_B : REQ_A;
      trk1       <= trk0;
    end
  end

  assign ram_blk_select = ram_wr_en | ram_rd_en;

  assign a_rvalid = trk1.valid & (trk1.id == REQ_A);
  assign b_rvalid = trk1.valid & (trk1.id == REQ_B);
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and an rvalid scoreboard.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_wr, b_req, b_wr;
  logic [9:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        ram_wr_en, ram_rd_en, ram_blk_select;
  logic [9:0]  ram_addr_wr, ram_addr_rd;
  logic [15:0] ram_din, ram_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  ram_port_arbiter #(.MEM_WIDTH(16), .ADDR_SIZE(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_blk_select(ram_blk_select),
    .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port RAM with registered read (old data on same-cycle collision)
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr_wr] <= ram_din;
    if (ram_rd_en) ram_dout <= mem[ram_addr_rd];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever read data is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL rvalid_missing: no rvalid, expected side %0d data %0h at cycle %0d", mon_e.id, mon_e.data, mon_e.due);
      end
      if (a_rvalid && b_rvalid) begin
        checks++;
        errors++;
        $display("FAIL rvalid_both: both rvalid high at cycle %0d", cyc);
      end else if (a_rvalid || b_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: side %0d rvalid at cycle %0d, none expected", b_rvalid, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.id !== b_rvalid || mon_e.due != cyc ||
              (b_rvalid ? b_rdata : a_rdata) !== mon_e.data) begin
            errors++;
            $display("FAIL rdata: got side %0d data %0h cycle %0d, expected side %0d data %0h cycle %0d",
                     b_rvalid, b_rvalid ? b_rdata : a_rdata, cyc, mon_e.id, mon_e.data, mon_e.due);
          end
        end
      end
    end
  end

  task automatic step(input logic ar, input logic aw, input logic [9:0] aa, input logic [15:0] ad,
                      input logic br, input logic bw, input logic [9:0] ba, input logic [15:0] bd,
                      input logic eag, input logic ebg,
                      input logic [15:0] ard, input logic [15:0] brd, input string nm);
    a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    chk({nm, "_a_gnt"}, 32'(a_gnt), 32'(eag));
    chk({nm, "_b_gnt"}, 32'(b_gnt), 32'(ebg));
    if (eag && ar && !aw) sb.push_back('{id: REQ_A, data: ard, due: cyc + 2});
    if (ebg && br && !bw) sb.push_back('{id: REQ_B, data: brd, due: cyc + 2});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0, 0, 0, 16'h0, 16'h0, "idle");
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_a_gnt"}, 32'(a_gnt), 0);
    chk({nm, "_b_gnt"}, 32'(b_gnt), 0);
    chk({nm, "_wr_en"}, 32'(ram_wr_en), 0);
    chk({nm, "_rd_en"}, 32'(ram_rd_en), 0);
    chk({nm, "_blk"}, 32'(ram_blk_select), 0);
    chk({nm, "_addr_wr"}, 32'(ram_addr_wr), 0);
    chk({nm, "_addr_rd"}, 32'(ram_addr_rd), 0);
    chk({nm, "_din"}, 32'(ram_din), 0);
    chk({nm, "_a_rvalid"}, 32'(a_rvalid), 0);
    chk({nm, "_b_rvalid"}, 32'(b_rvalid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 1; a_wr = 1; a_addr = 10'd0; a_wdata = 16'h1111;
    b_req = 1; b_wr = 1; b_addr = 10'd0; b_wdata = 16'h2222;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Conflicting writes after reset: A first, then B
    step(1, 1, 10'd0, 16'h1111, 1, 1, 10'd0, 16'h2222, 1, 0, 16'h0, 16'h0, "rst_first");
    step(0, 0, 10'd0, 16'h0,    1, 1, 10'd0, 16'h2222, 0, 1, 16'h0, 16'h0, "b_w0");

    // Single write then read of the same address
    step(1, 1, 10'd5, 16'h1234, 0, 0, 10'd0, 16'h0, 1, 0, 16'h0, 16'h0, "a_w5");
    chk("w5_wr_en", 32'(ram_wr_en), 1);
    chk("w5_rd_en", 32'(ram_rd_en), 0);
    chk("w5_addr", 32'(ram_addr_wr), 5);
    chk("w5_din", 32'(ram_din), 32'h1234);
    chk("w5_blk", 32'(ram_blk_select), 1);
    step(1, 0, 10'd5, 16'h0, 0, 0, 10'd0, 16'h0, 1, 0, 16'h1234, 16'h0, "a_r5");
    chk("r5_rd_en", 32'(ram_rd_en), 1);
    chk("r5_wr_en", 32'(ram_wr_en), 0);
    chk("r5_addr", 32'(ram_addr_rd), 5);

    // Preload addresses 7 and 9
    step(0, 0, 10'd0, 16'h0,    1, 1, 10'd7, 16'h0077, 0, 1, 16'h0, 16'h0, "b_w7");
    step(1, 1, 10'd9, 16'h0999, 0, 0, 10'd0, 16'h0,    1, 0, 16'h0, 16'h0, "a_w9");

    // Dual issue: A writes 3, B reads 7
    step(1, 1, 10'd3, 16'hBEEF, 1, 0, 10'd7, 16'h0, 1, 1, 16'h0, 16'h0077, "dual");
    chk("dual_wr_en", 32'(ram_wr_en), 1);
    chk("dual_rd_en", 32'(ram_rd_en), 1);
    chk("dual_addr_wr", 32'(ram_addr_wr), 3);
    chk("dual_addr_rd", 32'(ram_addr_rd), 7);
    chk("dual_din", 32'(ram_din), 32'hBEEF);

    // Collision on addr 9 with prio=B: B reads old value, A writes next cycle
    step(1, 1, 10'd9, 16'hAAAA, 1, 0, 10'd9, 16'h0, 0, 1, 16'h0, 16'h0999, "coll");
    step(1, 1, 10'd9, 16'hAAAA, 0, 0, 10'd0, 16'h0, 1, 0, 16'h0, 16'h0, "coll_a");
    step(0, 0, 10'd0, 16'h0,    1, 0, 10'd9, 16'h0, 0, 1, 16'h0, 16'hAAAA, "b_r9_new");

    // Fairness: both read continuously, grants alternate starting with A
    for (int i = 0; i < 6; i++)
      step(1, 0, 10'd5, 16'h0, 1, 0, 10'd3, 16'h0, (i % 2) == 0, (i % 2) == 1,
           16'h1234, 16'hBEEF, "fair");
    idle(3);

    // Async reset one cycle after a read grant (this grant also moves prio to B)
    step(1, 0, 10'd5, 16'h0, 1, 0, 10'd5, 16'h0, 1, 0, 16'h1234, 16'h0, "pre_rst");
    chk("pre_rst_rd_en", 32'(ram_rd_en), 1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("async");
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_a_rvalid", 32'(a_rvalid), 0);
      chk("rst_hold_b_rvalid", 32'(b_rvalid), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 1, 10'd2, 16'h5555, 1, 1, 10'd2, 16'h6666, 1, 0, 16'h0, 16'h0, "post_rst");
    step(0, 0, 10'd0, 16'h0,    1, 1, 10'd2, 16'h6666, 0, 1, 16'h0, 16'h0, "post_rst_b");
    idle(4);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
